// File: rtl/inst_loader_if.sv
// Bundles the user-facing loader signals: button, switch byte and the idle qualifier
// into the loader, and the assembled instruction plus status back out to
// fsm_control and the datapath.
interface inst_loader_if;
  logic        btn_raw;
  logic [7:0]  data_in;
  logic        fsm_idle;
  logic [15:0] inst;
  logic [3:0]  opcode;
  logic        inst_done;
  logic        btn_edge;
  logic [1:0]  load_cnt;

  // Loader side: consumes button/data/idle, produces instruction and status.
  modport slave (
    input  btn_raw, data_in, fsm_idle,
    output inst, opcode, inst_done, btn_edge, load_cnt
  );

  // Driver side: user switches / control FSM.
  modport master (
    output btn_raw, data_in, fsm_idle,
    input  inst, opcode, inst_done, btn_edge, load_cnt
  );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: front end of the bit-serial CPU.
// Synchronizes and debounces the push-button, turns each accepted press into a
// one-cycle btn_edge pulse, and assembles a 16-bit instruction from two byte
// loads (press 1 = high byte, press 2 = low byte, press 3 = execute).
// The load state advances at the end of the btn_edge cycle, so during that pulse
// fsm_control still sees the pre-press state (inst_done=1 on the execute press).
module inst_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int INST_W          = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  inst_loader_if.slave  io_bus
);

  localparam int                CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_deb;
  logic              r_deb_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_btn_edge;
  state_t            r_state;
  logic [INST_W-1:0] r_inst;

  state_t            w_state_nxt;
  logic [INST_W-1:0] w_inst_nxt;
  logic              w_press;
  logic              w_accept;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= io_bus.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_deb      <= 1'b0;
      r_deb_prev <= 1'b0;
    end else begin
      r_deb_prev <= r_deb;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A press is the debounced rise; it only counts while fsm_control is idle.
  assign w_press  = r_deb & ~r_deb_prev;
  assign w_accept = w_press & io_bus.fsm_idle;

  // Next-state and instruction assembly, taken at the end of the btn_edge cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_inst_nxt  = r_inst;
    if (r_btn_edge) begin
      case (r_state)
        S_EMPTY: begin
          w_state_nxt = S_HALF;
          w_inst_nxt  = {io_bus.data_in, r_inst[7:0]};
        end
        S_HALF: begin
          w_state_nxt = S_FULL;
          w_inst_nxt  = {r_inst[INST_W-1:8], io_bus.data_in};
        end
        S_FULL: begin
          w_state_nxt = S_EMPTY;
          w_inst_nxt  = r_inst;
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_inst_nxt  = r_inst;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_inst_nxt  = r_inst;
    end
  end

  // State, instruction and press-pulse registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_EMPTY;
      r_inst     <= '0;
      r_btn_edge <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inst     <= w_inst_nxt;
      r_btn_edge <= w_accept;
    end
  end

  assign io_bus.inst      = r_inst;
  assign io_bus.opcode    = r_inst[INST_W-1 -: 4];
  assign io_bus.inst_done = (r_state == S_FULL);
  assign io_bus.btn_edge  = r_btn_edge;
  assign io_bus.load_cnt  = r_state;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with DEBOUNCE_CYCLES=4: glitch rejection, press
// latency, bounce immunity, byte assembly, execute press, idle gating and reset.
module tb_inst_loader;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   pulses;
  int   first;

  inst_loader_if bus ();

  inst_loader #(.DEBOUNCE_CYCLES(4), .INST_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step n cycles (sampling at negedge), counting btn_edge pulses and first pulse index.
  task automatic run(input int n, output int cnt, output int first_at);
    cnt = 0;
    first_at = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.btn_edge === 1'b1) begin
        cnt++;
        if (first_at == 0) first_at = i;
      end
    end
  endtask

  // Full press: hold high 12 cycles, release 10 cycles; returns pulse count.
  task automatic press(input logic [7:0] d, output int cnt);
    int c1, c2, f;
    bus.data_in = d;
    bus.btn_raw = 1'b1;
    run(12, c1, f);
    bus.btn_raw = 1'b0;
    run(10, c2, f);
    cnt = c1 + c2;
  endtask

  initial begin
    int c, f;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.btn_raw  = 1'b0;
    bus.data_in  = 8'h00;
    bus.fsm_idle = 1'b1;
    run(3, c, f);
    chk("rst_inst", 32'(bus.inst), 32'h0);
    chk("rst_btn_edge", 32'(bus.btn_edge), 32'h0);
    chk("rst_load_cnt", 32'(bus.load_cnt), 32'h0);
    chk("rst_inst_done", 32'(bus.inst_done), 32'h0);
    rst_n = 1'b1;
    run(2, c, f);

    // 1: 3-cycle glitch is rejected
    bus.btn_raw = 1'b1;
    run(3, c, f);
    bus.btn_raw = 1'b0;
    run(20, pulses, f);
    chk("glitch_pulses", 32'(c + pulses), 32'd0);
    chk("glitch_load_cnt", 32'(bus.load_cnt), 32'd0);

    // 2: clean press, latency 7 cycles, no repeat while held
    bus.data_in = 8'h1A;
    bus.btn_raw = 1'b1;
    run(7, pulses, first);
    chk("clean_first_at", 32'(first), 32'd7);
    chk("clean_pulses", 32'(pulses), 32'd1);
    run(1, c, f);
    chk("clean_load_cnt", 32'(bus.load_cnt), 32'd1);
    chk("clean_inst_hi", 32'(bus.inst[15:8]), 32'h1A);
    run(100, pulses, f);
    chk("held_no_pulse", 32'(pulses), 32'd0);
    bus.btn_raw = 1'b0;
    run(20, pulses, f);
    chk("release_no_pulse", 32'(pulses), 32'd0);

    // 3: bouncy press gives one pulse (low byte 8'h55)
    bus.data_in = 8'h55;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw = ~bus.btn_raw;
      run(1, c, f);
      pulses += c;
    end
    bus.btn_raw = 1'b1;
    run(20, c, f);
    pulses += c;
    bus.btn_raw = 1'b0;
    run(15, c, f);
    pulses += c;
    chk("bounce_pulses", 32'(pulses), 32'd1);
    chk("bounce_inst", 32'(bus.inst), 32'h1A55);
    chk("bounce_done", 32'(bus.inst_done), 32'd1);
    press(8'h77, pulses);
    chk("exec1_pulses", 32'(pulses), 32'd1);
    chk("exec1_load_cnt", 32'(bus.load_cnt), 32'd0);

    // 4: assemble 8F03 and execute
    press(8'h8F, pulses);
    chk("ld_hi_load_cnt", 32'(bus.load_cnt), 32'd1);
    press(8'h03, pulses);
    chk("ld_inst", 32'(bus.inst), 32'h8F03);
    chk("ld_opcode", 32'(bus.opcode), 32'h8);
    chk("ld_done", 32'(bus.inst_done), 32'd1);
    chk("ld_load_cnt", 32'(bus.load_cnt), 32'd2);
    bus.data_in = 8'hEE;
    bus.btn_raw = 1'b1;
    run(7, pulses, first);
    chk("exec_first_at", 32'(first), 32'd7);
    chk("exec_edge_done", 32'(bus.inst_done), 32'd1);
    run(1, c, f);
    chk("exec_after_edge", 32'(bus.btn_edge), 32'd0);
    chk("exec_after_done", 32'(bus.inst_done), 32'd0);
    chk("exec_after_inst", 32'(bus.inst), 32'h8F03);
    bus.btn_raw = 1'b0;
    run(12, c, f);

    // 5: press while not idle is dropped
    bus.fsm_idle = 1'b0;
    press(8'hFF, pulses);
    chk("busy_pulses", 32'(pulses), 32'd0);
    chk("busy_inst", 32'(bus.inst), 32'h8F03);
    chk("busy_load_cnt", 32'(bus.load_cnt), 32'd0);
    bus.fsm_idle = 1'b1;

    // 6: reset in HALF, then rebuild
    press(8'h22, pulses);
    chk("half_inst", 32'(bus.inst), 32'h2203);
    rst_n = 1'b0;
    run(1, c, f);
    rst_n = 1'b1;
    chk("mrst_inst", 32'(bus.inst), 32'h0);
    chk("mrst_load_cnt", 32'(bus.load_cnt), 32'd0);
    chk("mrst_done", 32'(bus.inst_done), 32'd0);
    chk("mrst_opcode", 32'(bus.opcode), 32'h0);
    press(8'hC4, pulses);
    press(8'h5B, c);
    chk("rebuild_pulses", 32'(pulses + c), 32'd2);
    chk("rebuild_inst", 32'(bus.inst), 32'hC45B);
    chk("rebuild_opcode", 32'(bus.opcode), 32'hC);
    chk("rebuild_load_cnt", 32'(bus.load_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
